// File: rtl/goalie_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : goalie_motion_ctrl
//  Description : Stepper-motor positioning controller for a table-football
//                goalie carriage. Homes against a limit switch, then moves
//                to one of eight slots with fixed-width step pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module goalie_motion_ctrl #(
   parameter int STEP_PERIOD    = 50000,
   parameter int STEPS_PER_SLOT = 200,
   parameter int HOME_BACKOFF   = 20,
   parameter int MAX_HOME_STEPS = 4000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        home_req,
   input  logic        limit_switch,
   input  logic        target_valid,
   input  logic [2:0]  target_addr,
   output logic        step,
   output logic        dir,
   output logic        busy,
   output logic        homed,
   output logic        fault,
   output logic [15:0] position,
   output logic [31:0] status
);

   localparam logic [15:0] c_PHASE_LAST = 16'(STEP_PERIOD - 1);
   localparam logic [15:0] c_SLOT_STEPS = 16'(STEPS_PER_SLOT);
   localparam logic [15:0] c_MAX_SEEK   = 16'(MAX_HOME_STEPS);
   localparam logic [15:0] c_BACKOFF    = 16'(HOME_BACKOFF);

   typedef enum logic [2:0] {
      S_UNHOMED      = 3'd0,
      S_HOME_SEEK    = 3'd1,
      S_HOME_BACKOFF = 3'd2,
      S_READY        = 3'd3,
      S_MOVE         = 3'd4,
      S_FAULT        = 3'd5
   } state_t;

   state_t      r_state;
   logic        r_lim_meta;
   logic        r_lim_s;
   logic        r_active;
   logic        r_step;
   logic        r_dir;
   logic        r_busy;
   logic        r_homed;
   logic        r_fault;
   logic [15:0] r_phase_cnt;
   logic [15:0] r_step_cnt;
   logic [15:0] r_position;
   logic [15:0] r_target;
   logic [2:0]  r_addr;

   logic        w_decide;
   logic [15:0] w_new_target;

   // Decision point: no pulse in flight, or the last cycle of a low phase
   assign w_decide     = !r_active || (!r_step && (r_phase_cnt == c_PHASE_LAST));
   assign w_new_target = 16'(target_addr) * c_SLOT_STEPS;

   // Two-flop synchronizer for the asynchronous limit switch
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_lim_meta <= 1'b0;
         r_lim_s    <= 1'b0;
      end else begin
         r_lim_meta <= limit_switch;
         r_lim_s    <= r_lim_meta;
      end
   end

   // Pulse engine and motion state machine with registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_UNHOMED;
         r_active    <= 1'b0;
         r_step      <= 1'b0;
         r_dir       <= 1'b0;
         r_busy      <= 1'b0;
         r_homed     <= 1'b0;
         r_fault     <= 1'b0;
         r_phase_cnt <= '0;
         r_step_cnt  <= '0;
         r_position  <= '0;
         r_target    <= '0;
         r_addr      <= '0;
      end else begin
         // A started pulse always runs to completion unless a fault kills it
         if (r_active) begin
            if (r_phase_cnt == c_PHASE_LAST) begin
               r_phase_cnt <= '0;
               if (r_step) begin
                  r_step <= 1'b0;
               end else begin
                  r_active <= 1'b0;
               end
            end else begin
               r_phase_cnt <= r_phase_cnt + 16'd1;
            end
         end

         case (r_state)
            S_UNHOMED: begin
               if (home_req) begin
                  r_state    <= S_HOME_SEEK;
                  r_busy     <= 1'b1;
                  r_step_cnt <= '0;
               end
            end

            S_HOME_SEEK: begin
               if (w_decide) begin
                  if (r_lim_s) begin
                     r_state    <= S_HOME_BACKOFF;
                     r_step_cnt <= '0;
                  end else if (r_step_cnt >= c_MAX_SEEK) begin
                     r_state <= S_FAULT;
                     r_busy  <= 1'b0;
                     r_fault <= 1'b1;
                  end else if (enable) begin
                     r_active    <= 1'b1;
                     r_step      <= 1'b1;
                     r_phase_cnt <= '0;
                     r_dir       <= 1'b0;
                     r_step_cnt  <= r_step_cnt + 16'd1;
                  end
               end
            end

            S_HOME_BACKOFF: begin
               // The switch is still closed while backing off, so it is ignored here
               if (w_decide) begin
                  if (r_step_cnt >= c_BACKOFF) begin
                     r_state    <= S_READY;
                     r_busy     <= 1'b0;
                     r_homed    <= 1'b1;
                     r_position <= '0;
                     r_target   <= '0;
                  end else if (enable) begin
                     r_active    <= 1'b1;
                     r_step      <= 1'b1;
                     r_phase_cnt <= '0;
                     r_dir       <= 1'b1;
                     r_step_cnt  <= r_step_cnt + 16'd1;
                  end
               end
            end

            S_READY: begin
               if (r_lim_s) begin
                  r_state <= S_FAULT;
                  r_homed <= 1'b0;
                  r_fault <= 1'b1;
               end else if (home_req) begin
                  r_state    <= S_HOME_SEEK;
                  r_busy     <= 1'b1;
                  r_homed    <= 1'b0;
                  r_step_cnt <= '0;
               end else if (target_valid) begin
                  r_addr   <= target_addr;
                  r_target <= w_new_target;
               end else if (r_target != r_position) begin
                  r_state <= S_MOVE;
                  r_busy  <= 1'b1;
               end
            end

            S_MOVE: begin
               if (r_lim_s) begin
                  r_state     <= S_FAULT;
                  r_active    <= 1'b0;
                  r_step      <= 1'b0;
                  r_phase_cnt <= '0;
                  r_busy      <= 1'b0;
                  r_homed     <= 1'b0;
                  r_fault     <= 1'b1;
               end else begin
                  // A new target is captured now but only steers the next decision
                  if (target_valid) begin
                     r_addr   <= target_addr;
                     r_target <= w_new_target;
                  end
                  if (w_decide) begin
                     if (r_position == r_target) begin
                        r_state <= S_READY;
                        r_busy  <= 1'b0;
                     end else if (enable) begin
                        r_active    <= 1'b1;
                        r_step      <= 1'b1;
                        r_phase_cnt <= '0;
                        if (r_target > r_position) begin
                           r_dir      <= 1'b1;
                           r_position <= r_position + 16'd1;
                        end else begin
                           r_dir      <= 1'b0;
                           r_position <= r_position - 16'd1;
                        end
                     end
                  end
               end
            end

            S_FAULT: begin
               if (home_req) begin
                  r_state    <= S_HOME_SEEK;
                  r_busy     <= 1'b1;
                  r_fault    <= 1'b0;
                  r_step_cnt <= '0;
               end
            end

            default: begin
               r_state <= S_UNHOMED;
               r_busy  <= 1'b0;
               r_fault <= 1'b0;
            end
         endcase
      end
   end

   assign step     = r_step;
   assign dir      = r_dir;
   assign busy     = r_busy;
   assign homed    = r_homed;
   assign fault    = r_fault;
   assign position = r_position;
   assign status   = {23'd0, r_fault, r_homed, r_busy, r_state, r_addr};

endmodule
`default_nettype wire

// File: tb/tb_goalie_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_goalie_motion_ctrl
//  Description : Randomized self-checking bench for goalie_motion_ctrl with a
//                pulse-level reference model of carriage position.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_goalie_motion_ctrl;

   localparam int P    = 4;
   localparam int SPS  = 10;
   localparam int HB   = 3;
   localparam int MAXH = 100;

   logic        clk = 1'b0;
   logic        reset_n, enable, home_req, limit_switch, target_valid;
   logic [2:0]  target_addr;
   logic        step, dir, busy, homed, fault;
   logic [15:0] position;
   logic [31:0] status;

   always #5 clk = ~clk;

   goalie_motion_ctrl #(
      .STEP_PERIOD    (P),
      .STEPS_PER_SLOT (SPS),
      .HOME_BACKOFF   (HB),
      .MAX_HOME_STEPS (MAXH)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .home_req     (home_req),
      .limit_switch (limit_switch),
      .target_valid (target_valid),
      .target_addr  (target_addr),
      .step         (step),
      .dir          (dir),
      .busy         (busy),
      .homed        (homed),
      .fault        (fault),
      .position     (position),
      .status       (status)
   );

   int   n_chk = 0, n_fail = 0;
   int   rises = 0, rises_up = 0, rises_dn = 0;
   int   high_len = 0, low_len = 100;
   logic prev_step = 1'b0, prev_en = 1'b0, rise_dir = 1'b0;
   bit   mon_len = 1'b1, mv = 1'b0, rand_en = 1'b0;
   int   m_pos = 0, m_tgt = 0;

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Pulse-level observer: widths, enable gating, direction and model position
   task automatic monitor();
      bit exp_up;
      if (step && !prev_step) begin
         rises++;
         if (dir) rises_up++; else rises_dn++;
         rise_dir = dir;
         chk("start_with_enable", int'(prev_en), 1);
         if (mon_len) chk("low_len_min", int'(low_len >= P), 1);
         if (mv) begin
            exp_up = (m_tgt > m_pos);
            chk("move_dir", int'(dir), int'(exp_up));
            m_pos = exp_up ? m_pos + 1 : m_pos - 1;
            chk("move_pos", int'(position), m_pos);
         end
         high_len = 1;
      end else if (step) begin
         high_len++;
      end
      if (!step && prev_step) begin
         if (mon_len) begin
            chk("high_len", high_len, P);
            chk("dir_hold", int'(dir), int'(rise_dir));
         end
         low_len = 1;
      end else if (!step) begin
         low_len++;
      end
      prev_step = step;
      prev_en   = enable;
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #2;
      if (rand_en) enable = ($urandom_range(0, 5) != 0);
   endtask

   task automatic do_home(input int n_seek);
      int b_dn, b_up;
      bit lim_on, done;
      lim_on = 0; done = 0;
      home_req = 1'b1; tick(); home_req = 1'b0;
      chk("home_seek_state", int'(status[5:3]), 1);
      b_dn = rises_dn; b_up = rises_up;
      for (int k = 0; k < 3000 && !done; k++) begin
         tick();
         if (!lim_on && (rises_dn - b_dn) == n_seek) begin
            limit_switch = 1'b1;
            lim_on = 1;
         end
         if (limit_switch && (rises_up - b_up) >= 1) limit_switch = 1'b0;
         if (lim_on && !busy) done = 1;
      end
      chk("home_done", int'(done), 1);
      chk("seek_pulses", rises_dn - b_dn, n_seek);
      chk("backoff_pulses", rises_up - b_up, HB);
      chk("homed", int'(homed), 1);
      chk("home_position", int'(position), 0);
      chk("home_ready_state", int'(status[5:3]), 3);
      m_pos = 0;
   endtask

   task automatic do_move(input int addr, input bit allow_rt);
      int base, exp_total, rt_at, nw;
      bit rt, rt_done, done;
      rt_done = 0; done = 0; rt_at = 0;
      target_valid = 1'b1; target_addr = 3'(addr); tick(); target_valid = 1'b0;
      m_tgt = addr * SPS;
      base = rises;
      exp_total = iabs(m_tgt - m_pos);
      mv = 1;
      rt = allow_rt && (exp_total > 2) && ($urandom_range(0, 1) == 1);
      if (rt) rt_at = $urandom_range(1, exp_total - 1);
      for (int k = 0; k < 4000 && !done; k++) begin
         tick();
         if (rt && !rt_done && step && high_len == 1 && (rises - base) == rt_at) begin
            nw = $urandom_range(0, 7);
            target_valid = 1'b1; target_addr = 3'(nw); tick(); target_valid = 1'b0;
            m_tgt = nw * SPS;
            exp_total = (rises - base) + iabs(m_tgt - m_pos);
            addr = nw;
            rt_done = 1;
         end
         if (k >= 3 && !busy) done = 1;
      end
      mv = 0;
      chk("move_done", int'(done), 1);
      chk("move_final_pos", int'(position), m_tgt);
      chk("move_pulse_count", rises - base, exp_total);
      chk("move_ready_state", int'(status[5:3]), 3);
      chk("move_addr_latched", int'(status[2:0]), addr);
   endtask

   initial begin
      int b, lat, base;
      bit done;
      reset_n = 1'b0; enable = 1'b1; home_req = 1'b0; limit_switch = 1'b0;
      target_valid = 1'b0; target_addr = 3'd0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_step", int'(step), 0);
      chk("rst_dir", int'(dir), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_homed", int'(homed), 0);
      chk("rst_fault", int'(fault), 0);
      chk("rst_position", int'(position), 0);
      chk("rst_status", int'(status), 0);
      reset_n = 1'b1;
      tick();

      // Homing with the switch closing after five seek pulses
      do_home(5);

      // Directed first move to slot 2, then randomized moves with retargets
      do_move(2, 0);
      rand_en = 1;
      for (int i = 0; i < 10; i++) do_move($urandom_range(0, 7), 1);
      rand_en = 0; enable = 1'b1;

      // Spurious limit during a move
      target_valid = 1'b1; target_addr = (m_pos == 0) ? 3'd7 : 3'd0; tick(); target_valid = 1'b0;
      m_tgt = (m_pos == 0) ? 7 * SPS : 0;
      mv = 1; base = rises; done = 0;
      for (int k = 0; k < 200 && !done; k++) begin
         tick();
         if (rises - base >= 2) done = 1;
      end
      chk("spur_move_started", int'(done), 1);
      mon_len = 0;
      limit_switch = 1'b1;
      lat = 0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (fault && lat == 0) lat = k;
      end
      mv = 0;
      chk("spur_fault_latency", int'(lat > 0 && lat <= 3), 1);
      chk("spur_fault", int'(fault), 1);
      chk("spur_homed", int'(homed), 0);
      chk("spur_step", int'(step), 0);
      chk("spur_busy", int'(busy), 0);
      chk("spur_state", int'(status[5:3]), 5);
      limit_switch = 1'b0;
      repeat (4) tick();
      mon_len = 1;

      // Seek timeout with the switch never closing
      home_req = 1'b1; tick(); home_req = 1'b0;
      chk("timeout_seek_state", int'(status[5:3]), 1);
      b = rises_dn; done = 0;
      for (int k = 0; k < 1500 && !done; k++) begin
         tick();
         if (fault) done = 1;
      end
      chk("timeout_fault", int'(done), 1);
      chk("timeout_pulses", rises_dn - b, MAXH);
      chk("timeout_step", int'(step), 0);
      chk("timeout_busy", int'(busy), 0);
      chk("timeout_state", int'(status[5:3]), 5);
      home_req = 1'b1; tick(); home_req = 1'b0;
      chk("reseek_state", int'(status[5:3]), 1);
      do_home(4);

      // Reset in the middle of a move, then hold enable low
      target_valid = 1'b1; target_addr = 3'd7; tick(); target_valid = 1'b0;
      base = rises; done = 0;
      for (int k = 0; k < 300 && !done; k++) begin
         tick();
         if (rises - base >= 3) done = 1;
      end
      chk("rstmove_started", int'(done), 1);
      tick();
      mon_len = 0;
      reset_n = 1'b0;
      #1;
      chk("rstmove_step", int'(step), 0);
      chk("rstmove_dir", int'(dir), 0);
      chk("rstmove_busy", int'(busy), 0);
      chk("rstmove_homed", int'(homed), 0);
      chk("rstmove_fault", int'(fault), 0);
      chk("rstmove_position", int'(position), 0);
      chk("rstmove_status", int'(status), 0);
      enable = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (2) tick();
      mon_len = 1;
      home_req = 1'b1; tick(); home_req = 1'b0;
      b = rises;
      repeat (60) tick();
      chk("disabled_no_pulse", rises - b, 0);
      chk("disabled_step", int'(step), 0);
      chk("disabled_state", int'(status[5:3]), 1);
      chk("disabled_busy", int'(busy), 1);
      enable = 1'b1;
      repeat (4) tick();
      chk("enabled_pulse_starts", int'(rises > b), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
